// File: rtl/dff_ram_arb_pkg.sv
// dff_ram_arb_pkg: shared types and default sizes for the 4x72 flop-RAM arbiter
package dff_ram_arb_pkg;
  localparam int DATA_W_DEF = 72;
  localparam int ADDR_W_DEF = 2;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter, one-hot grant, remembers the last accepted port
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);
  logic r_rr_last;
  always_comb grant = (valid == 2'b11) ? (r_rr_last ? 2'b01 : 2'b10) : valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rr_last <= 1'b1;
    else if (accept) r_rr_last <= grant[1];
endmodule

// File: rtl/dff_ram_4x72_arb.sv
// dff_ram_4x72_arb: zero-initialises the flop RAM, then round-robins two clients onto it.
// DFF_RAM_ARB_PERF_EN adds saturating per-port stall counters perf_stall0/perf_stall1.
module dff_ram_4x72_arb
  import dff_ram_arb_pkg::*;
#(
  parameter int                DATA_W     = DATA_W_DEF,
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              ram_en_n,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              init_done
`ifdef DFF_RAM_ARB_PERF_EN
  ,
  output logic [15:0]       perf_stall0,
  output logic [15:0]       perf_stall1
`endif
);
  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_init_cnt;
  logic [1:0]        r_rsp;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_run;
  logic              w_init;
  logic              w_acc;
  logic [1:0]        w_valid;
  logic [1:0]        w_grant;
  req_t              w_req;
  assign w_valid = {req1_valid, req0_valid};
  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  (w_valid),
    .accept (w_acc),
    .grant  (w_grant)
  );
  // rst_n gates the INIT drive so the RAM stays disabled while reset is held
  always_comb begin
    w_run       = r_state == ST_RUN;
    w_init      = (r_state == ST_INIT) && rst_n;
    w_acc       = w_run && |w_valid;
    w_req       = w_grant[1] ? req_t'{req1_we, req1_addr, req1_wdata}
                             : req_t'{req0_we, req0_addr, req0_wdata};
    w_state_nxt = (r_state == ST_INIT && r_init_cnt == '1) ? ST_RUN : r_state;
    req0_ready  = w_run && w_grant[0];
    req1_ready  = w_run && w_grant[1];
    ram_en_n    = !(w_init || w_acc);
    ram_wr      = w_init ? 1'b0 : w_acc ? !w_req.we : r_wr;
    ram_address = w_init ? r_init_cnt : w_acc ? w_req.addr : r_addr;
    ram_wdata   = w_init ? INIT_VALUE : w_acc ? w_req.wdata : r_wdata;
    rsp0_valid  = r_rsp[0];
    rsp1_valid  = r_rsp[1];
    rsp0_rdata  = r_rsp[0] ? ram_rdata : '0;
    rsp1_rdata  = r_rsp[1] ? ram_rdata : '0;
    init_done   = w_run;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_rsp      <= '0;
      r_wr       <= 1'b1;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init ? r_init_cnt + 1'b1 : r_init_cnt;
      r_rsp      <= {2{w_acc && !w_req.we}} & w_grant;
      r_wr       <= ram_wr;
      r_addr     <= ram_address;
      r_wdata    <= ram_wdata;
    end
`ifdef DFF_RAM_ARB_PERF_EN
  logic [15:0] r_perf_stall0;
  logic [15:0] r_perf_stall1;
  assign perf_stall0 = r_perf_stall0;
  assign perf_stall1 = r_perf_stall1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_perf_stall0 <= '0;
      r_perf_stall1 <= '0;
    end else begin
      if (w_run && req0_valid && !req0_ready && r_perf_stall0 != '1) r_perf_stall0 <= r_perf_stall0 + 1'b1;
      if (w_run && req1_valid && !req1_ready && r_perf_stall1 != '1) r_perf_stall1 <= r_perf_stall1 + 1'b1;
    end
`endif
endmodule

// File: tb/tb_dff_ram_4x72_arb.sv
// tb_dff_ram_4x72_arb: randomized + directed bench with a behavioural arbiter/RAM scoreboard
module tb_dff_ram_4x72_arb;
  localparam logic [71:0] PAT  = 72'hAAAAAAAAA555555555;
  localparam logic [71:0] PAT2 = 72'h5A5A5A5A5A5A5A5A5A;
  logic        clk = 0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_we, rsp0_valid;
  logic [1:0]  req0_addr;
  logic [71:0] req0_wdata, rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we, rsp1_valid;
  logic [1:0]  req1_addr;
  logic [71:0] req1_wdata, rsp1_rdata;
  logic        ram_en_n, ram_wr, init_done;
  logic [1:0]  ram_address;
  logic [71:0] ram_wdata, ram_rdata;
`ifdef DFF_RAM_ARB_PERF_EN
  logic [15:0] perf_stall0, perf_stall1;
`endif
  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  dff_ram_4x72_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_en_n(ram_en_n), .ram_wr(ram_wr), .ram_address(ram_address),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .init_done(init_done)
`ifdef DFF_RAM_ARB_PERF_EN
    , .perf_stall0(perf_stall0), .perf_stall1(perf_stall1)
`endif
  );

  // the RAM macro itself: registered read, write on enable with ram_wr = 0
  logic [71:0] ram_mem [4];
  always @(posedge clk)
    if (!ram_en_n) begin
      if (!ram_wr) ram_mem[ram_address] <= ram_wdata;
      else ram_rdata <= ram_mem[ram_address];
    end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // scoreboard: contents array, last winner, pending response owner
  logic [71:0] exp_mem [4];
  int          m_init = 0, m_last = 1, m_rsp = -1, w;
  logic [71:0] m_data, h_wdata, d;
  logic [1:0]  h_addr, a;
  logic        we;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_en_n", 72'(ram_en_n), 72'(1));
      chk("rst_ready", 72'({req1_ready, req0_ready}), 72'(0));
      chk("rst_rsp", 72'({rsp1_valid, rsp0_valid}), 72'(0));
      chk("rst_done", 72'(init_done), 72'(0));
      m_init = 0; m_last = 1; m_rsp = -1;
    end else if (m_init < 4) begin
      chk("init_en_n", 72'(ram_en_n), 72'(0));
      chk("init_wr", 72'(ram_wr), 72'(0));
      chk("init_addr", 72'(ram_address), 72'(m_init));
      chk("init_wdata", ram_wdata, 72'(0));
      chk("init_ready", 72'({req1_ready, req0_ready}), 72'(0));
      chk("init_rsp", 72'({rsp1_valid, rsp0_valid}), 72'(0));
      chk("init_done", 72'(init_done), 72'(0));
      exp_mem[m_init] = '0; h_addr = 2'(m_init); h_wdata = '0; m_init++; m_rsp = -1;
    end else begin
      w = (req0_valid && req1_valid) ? 1 - m_last : req0_valid ? 0 : req1_valid ? 1 : -1;
      chk("done", 72'(init_done), 72'(1));
      chk("ready", 72'({req1_ready, req0_ready}), 72'(w == 0 ? 1 : w == 1 ? 2 : 0));
      chk("rsp0_valid", 72'(rsp0_valid), 72'(m_rsp == 0));
      chk("rsp0_rdata", rsp0_rdata, m_rsp == 0 ? m_data : 72'(0));
      chk("rsp1_valid", 72'(rsp1_valid), 72'(m_rsp == 1));
      chk("rsp1_rdata", rsp1_rdata, m_rsp == 1 ? m_data : 72'(0));
      if (w >= 0) begin
        we = w == 1 ? req1_we : req0_we;
        a  = w == 1 ? req1_addr : req0_addr;
        d  = w == 1 ? req1_wdata : req0_wdata;
        chk("acc_en_n", 72'(ram_en_n), 72'(0));
        chk("acc_wr", 72'(ram_wr), 72'(!we));
        chk("acc_addr", 72'(ram_address), 72'(a));
        if (we) begin
          chk("acc_wdata", ram_wdata, d);
          exp_mem[a] = d; m_rsp = -1;
        end else begin
          m_rsp = w; m_data = exp_mem[a];
        end
        m_last = w; h_addr = a; h_wdata = ram_wdata;
      end else begin
        chk("idle_en_n", 72'(ram_en_n), 72'(1));
        chk("idle_addr", 72'(ram_address), 72'(h_addr));
        chk("idle_wdata", ram_wdata, h_wdata);
        m_rsp = -1;
      end
    end
  end

  task automatic tick; @(posedge clk); #1; endtask
  task automatic set0(input logic v, input logic e, input logic [1:0] ad, input logic [71:0] dt);
    req0_valid = v; req0_we = e; req0_addr = ad; req0_wdata = dt;
  endtask
  task automatic set1(input logic v, input logic e, input logic [1:0] ad, input logic [71:0] dt);
    req1_valid = v; req1_we = e; req1_addr = ad; req1_wdata = dt;
  endtask

  logic a0, a1;
  initial begin
    rst_n = 0;
    set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    tick; tick;
    set0(1, 0, 0, 0); set1(1, 0, 1, 0);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lit_init_addr", 72'(ram_address), 72'(i));
      chk("lit_init_ready", 72'({req1_ready, req0_ready}), 72'(0));
      tick;
    end
    // contention from the first RUN cycle: 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lit_grant", 72'({req1_ready, req0_ready}), 72'(i % 2 == 0 ? 1 : 2));
      if (i > 0) chk("lit_rsp_owner", 72'({rsp1_valid, rsp0_valid}), 72'(i % 2 == 1 ? 1 : 2));
      tick;
    end
    set1(0, 0, 0, 0);
    set0(1, 1, 2, PAT);
    @(negedge clk); chk("lit_wr_ready", 72'(req0_ready), 72'(1)); tick;
    set0(1, 0, 2, 0);
    @(negedge clk); chk("lit_rd_ready", 72'(req0_ready), 72'(1)); tick;
    set0(0, 0, 0, 0);
    @(negedge clk);
    chk("lit_rsp0_valid", 72'(rsp0_valid), 72'(1));
    chk("lit_rsp0_rdata", rsp0_rdata, PAT);
    chk("lit_rsp1_quiet", 72'(rsp1_valid), 72'(0));
    tick;
    for (int k = 0; k < 3; k++) begin
      set1(1, 0, k == 0 ? 2'd3 : k == 1 ? 2'd1 : 2'd0, 0);
      @(negedge clk);
      chk("lit_p1_ready", 72'({req1_ready, req0_ready}), 72'(2));
      if (k > 0) chk("lit_p1_rsp", 72'({rsp1_valid, rsp1_rdata == 0}), 72'(3));
      tick;
    end
    set1(0, 0, 0, 0);
    @(negedge clk); chk("lit_p1_rsp_last", 72'({rsp1_valid, rsp1_rdata == 0}), 72'(3)); tick;
    // reset during a pending read
    set0(1, 1, 1, PAT2); tick;
    set0(1, 0, 1, 0);
    @(negedge clk); chk("lit_rd_ready2", 72'(req0_ready), 72'(1)); tick;
    rst_n = 0; set0(0, 0, 0, 0);
    @(negedge clk); chk("lit_rst_drop", 72'(rsp0_valid), 72'(0)); tick;
    @(negedge clk); chk("lit_rst_drop2", 72'(rsp0_valid), 72'(0)); tick;
    rst_n = 1;
    repeat (4) tick;
    set0(1, 0, 1, 0);
    @(negedge clk); chk("lit_post_rst_ready", 72'(req0_ready), 72'(1)); tick;
    set0(0, 0, 0, 0);
    @(negedge clk);
    chk("lit_post_rst_valid", 72'(rsp0_valid), 72'(1));
    chk("lit_post_rst_rdata", rsp0_rdata, 72'(0));
    tick;
    // random traffic; requests stay stable until accepted
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      tick;
      rst_n = !(rst_n && $urandom_range(0, 149) == 0);
      if (!req0_valid || a0)
        set0($urandom_range(0, 2) != 0, 1'($urandom), 2'($urandom), 72'({$urandom(), $urandom(), $urandom()}));
      if (!req1_valid || a1)
        set1($urandom_range(0, 2) != 0, 1'($urandom), 2'($urandom), 72'({$urandom(), $urandom(), $urandom()}));
    end
    rst_n = 1; set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    repeat (6) tick;
`ifdef DFF_RAM_ARB_PERF_EN
    rst_n = 0; tick; rst_n = 1;
    repeat (4) tick;
    set0(1, 0, 0, 0); set1(1, 0, 1, 0);
    repeat (10) tick;
    set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    @(negedge clk);
    chk("lit_perf0", 72'(perf_stall0), 72'(5));
    chk("lit_perf1", 72'(perf_stall1), 72'(5));
    tick;
    force dut.r_perf_stall0 = 16'hFFFE;
    #1 release dut.r_perf_stall0;
    set0(1, 0, 0, 0); set1(1, 0, 1, 0);
    repeat (4) tick;
    set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    @(negedge clk);
    chk("lit_perf0_sat", 72'(perf_stall0), 72'(16'hFFFF));
    chk("lit_perf1_cont", 72'(perf_stall1), 72'(7));
    tick;
`endif
    tick; tick;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
